// File: rtl/regheap_write_scheduler_pkg.sv
// rtl/regheap_write_scheduler_pkg.sv - shared encodings for the register heap write scheduler
package regheap_write_scheduler_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_WB   = 2'd1,
    REQ_LD   = 2'd2,
    REQ_DBG  = 2'd3
  } req_e;

  localparam logic [3:0] R0  = 4'd0;
  localparam logic [3:0] R1  = 4'd1;
  localparam logic [3:0] R2  = 4'd2;
  localparam logic [3:0] R3  = 4'd3;
  localparam logic [3:0] R4  = 4'd4;
  localparam logic [3:0] R5  = 4'd5;
  localparam logic [3:0] R6  = 4'd6;
  localparam logic [3:0] R7  = 4'd7;
  localparam logic [3:0] SP  = 4'd8;
  localparam logic [3:0] T   = 4'd9;
  localparam logic [3:0] IH  = 4'd10;
  localparam logic [3:0] RA  = 4'd11;
  localparam logic [3:0] EPC = 4'd12;

  localparam logic [3:0] EPC_IDX = EPC;

endpackage

// File: rtl/regheap_write_scheduler_rr_arbiter.sv
// rtl/regheap_write_scheduler_rr_arbiter.sv - 2-way round-robin arbiter with starvation override
module regheap_rr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_a_valid,
  input  logic i_b_valid,
  input  logic i_hold,
  output logic o_a_grant,
  output logic o_b_grant
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic          r_ptr_b;
  logic [CW-1:0] r_cnt_a;
  logic [CW-1:0] r_cnt_b;
  logic          w_a_starved;
  logic          w_b_starved;

  assign w_a_starved = i_a_valid && (r_cnt_a == LIM);
  assign w_b_starved = i_b_valid && (r_cnt_b == LIM);

  // Starvation beats the external hold (WB); a tie is broken by the pointer.
  always_comb begin
    o_a_grant = 1'b0;
    o_b_grant = 1'b0;
    if (w_a_starved && w_b_starved) begin
      o_a_grant = !r_ptr_b;
      o_b_grant = r_ptr_b;
    end else if (w_a_starved) begin
      o_a_grant = 1'b1;
    end else if (w_b_starved) begin
      o_b_grant = 1'b1;
    end else if (!i_hold) begin
      if (i_a_valid && i_b_valid) begin
        o_a_grant = !r_ptr_b;
        o_b_grant = r_ptr_b;
      end else begin
        o_a_grant = i_a_valid;
        o_b_grant = i_b_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr_b <= 1'b0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (o_a_grant) begin
        r_ptr_b <= 1'b1;
      end else if (o_b_grant) begin
        r_ptr_b <= 1'b0;
      end
      if (!i_a_valid || o_a_grant) begin
        r_cnt_a <= '0;
      end else if (r_cnt_a != LIM) begin
        r_cnt_a <= r_cnt_a + 1'b1;
      end
      if (!i_b_valid || o_b_grant) begin
        r_cnt_b <= '0;
      end else if (r_cnt_b != LIM) begin
        r_cnt_b <= r_cnt_b + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regheap_write_scheduler.sv
// rtl/regheap_write_scheduler.sv - shares the register heap write port among WB, LD and DBG
module regheap_write_scheduler
  import regheap_write_scheduler_pkg::*;
#(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [3:0] EPC_IDX      = regheap_write_scheduler_pkg::EPC_IDX
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_reg_i,
  input  logic [15:0] wb_data_i,
  output logic        wb_stall_o,
  input  logic        ld_valid_i,
  input  logic [3:0]  ld_reg_i,
  input  logic [15:0] ld_data_i,
  output logic        ld_ready_o,
  input  logic        dbg_valid_i,
  input  logic [3:0]  dbg_reg_i,
  input  logic [15:0] dbg_data_i,
  output logic        dbg_ready_o,
  output logic        regwrite_o,
  output logic [3:0]  wrreg_o,
  output logic [15:0] wdata_o,
  output logic [15:0] pend_o,
  output logic        prot_err_o
);

  logic        w_ld_grant;
  logic        w_dbg_grant;
  req_e        w_winner;
  logic [3:0]  w_sel_reg;
  logic [15:0] w_sel_data;
  logic [15:0] w_pend;

  logic        r_regwrite;
  logic [3:0]  r_wrreg;
  logic [15:0] r_wdata;
  logic        r_prot_err;

  regheap_rr_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk       (CLK),
    .rst_n     (RST),
    .i_a_valid (ld_valid_i),
    .i_b_valid (dbg_valid_i),
    .i_hold    (wb_we_i),
    .o_a_grant (w_ld_grant),
    .o_b_grant (w_dbg_grant)
  );

  always_comb begin
    w_winner   = REQ_NONE;
    w_sel_reg  = wb_reg_i;
    w_sel_data = wb_data_i;
    if (w_ld_grant) begin
      w_winner   = REQ_LD;
      w_sel_reg  = ld_reg_i;
      w_sel_data = ld_data_i;
    end else if (w_dbg_grant) begin
      w_winner   = REQ_DBG;
      w_sel_reg  = dbg_reg_i;
      w_sel_data = dbg_data_i;
    end else if (wb_we_i) begin
      w_winner = REQ_WB;
    end
  end

  assign ld_ready_o  = w_ld_grant;
  assign dbg_ready_o = w_dbg_grant;
  assign wb_stall_o  = wb_we_i && (w_winner != REQ_WB);

  // EPC writes are accepted on the handshake but never reach the heap;
  // address/data hold so the heap never sees the EPC index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_regwrite <= 1'b0;
      r_wrreg    <= '0;
      r_wdata    <= '0;
      r_prot_err <= 1'b0;
    end else if (w_winner == REQ_NONE) begin
      r_regwrite <= 1'b0;
      r_prot_err <= 1'b0;
    end else if (w_sel_reg == EPC_IDX) begin
      r_regwrite <= 1'b0;
      r_prot_err <= 1'b1;
    end else begin
      r_regwrite <= 1'b1;
      r_prot_err <= 1'b0;
      r_wrreg    <= w_sel_reg;
      r_wdata    <= w_sel_data;
    end
  end

  always_comb begin
    w_pend = '0;
    if (ld_valid_i && !w_ld_grant) begin
      w_pend[ld_reg_i] = 1'b1;
    end
    if (dbg_valid_i && !w_dbg_grant) begin
      w_pend[dbg_reg_i] = 1'b1;
    end
    if (wb_stall_o) begin
      w_pend[wb_reg_i] = 1'b1;
    end
    if (r_regwrite) begin
      w_pend[r_wrreg] = 1'b1;
    end
    w_pend[EPC_IDX] = 1'b0;
  end

  assign regwrite_o = r_regwrite;
  assign wrreg_o    = r_wrreg;
  assign wdata_o    = r_wdata;
  assign prot_err_o = r_prot_err;
  assign pend_o     = w_pend;

endmodule
